// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt aggregator: register select codes,
// service FSM states and the ACTIVE_ID register layout.
package irq_pkg;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_ACTIVE  = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int ACTIVE_VALID_BIT = 15;
    localparam int ID_W             = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQUEST    = 2'd1,
        IN_SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational priority encoder: reports the lowest set index of vec and
// whether any bit is set.
module irq_priority_encoder #(
    parameter int N = 8
) (
    input  logic [N-1:0] vec,
    output logic [3:0]   id,
    output logic         any
);

    always_comb begin
        id = 4'd0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                id = 4'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/irq_aggregator.sv
// Collects peripheral interrupts into pending/mask registers, requests the core
// via irq, and tracks the serviced source from ISR entry until rfi.
module irq_aggregator
    import irq_pkg::*;
#(
    parameter int          NUM_SOURCES = 8,
    parameter int          DATA_W      = 16,
    parameter logic [15:0] LEVEL_MASK  = 16'h0000,
    parameter logic [1:0]  PC_SAVE     = 2'h3
) (
    input  logic                   instr_clock,
    input  logic                   reset_n,
    input  logic [NUM_SOURCES-1:0] src,
    input  logic                   isr_ack,
    input  logic [1:0]             pc_mux_control,
    input  logic [1:0]             reg_sel,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   irq
);

    localparam logic [NUM_SOURCES-1:0] LEVEL = LEVEL_MASK[NUM_SOURCES-1:0];

    irq_state_t             state;
    irq_state_t             next_state;
    logic [NUM_SOURCES-1:0] pending;
    logic [NUM_SOURCES-1:0] mask;
    logic [NUM_SOURCES-1:0] src_q;
    logic                   gen;
    logic [ID_W-1:0]        active_id;
    logic                   active_valid;

    logic [NUM_SOURCES-1:0] cand;
    logic [ID_W-1:0]        winner;
    logic                   any;
    logic                   take_ack;
    logic                   take_rfi;
    logic [NUM_SOURCES-1:0] edge_set;
    logic [NUM_SOURCES-1:0] w1c;
    logic [NUM_SOURCES-1:0] ack_clr;
    logic [NUM_SOURCES-1:0] pending_next;
    logic                   unused_wr_bits;

    assign cand = pending & mask & {NUM_SOURCES{gen}};

    irq_priority_encoder #(
        .N (NUM_SOURCES)
    ) u_prio (
        .vec (cand),
        .id  (winner),
        .any (any)
    );

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:       if (any) next_state = REQUEST;
            REQUEST: begin
                // Losing the candidate before the ack withdraws the request.
                if (!any)         next_state = IDLE;
                else if (isr_ack) next_state = IN_SERVICE;
            end
            IN_SERVICE: if (pc_mux_control == PC_SAVE) next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    assign take_ack = (state == REQUEST) && any && isr_ack;
    assign take_rfi = (state == IN_SERVICE) && (pc_mux_control == PC_SAVE);

    // Edge sources: a fresh edge beats both software W1C and the ack clear.
    assign edge_set     = src & ~src_q;
    assign w1c          = (wr_en && reg_sel == REG_PENDING) ? wr_data[NUM_SOURCES-1:0] : '0;
    assign ack_clr      = take_ack ? (NUM_SOURCES'(1) << winner) : '0;
    assign pending_next = (LEVEL & src)
                        | (~LEVEL & ((pending & ~w1c & ~ack_clr) | edge_set));

    always_ff @(posedge instr_clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            pending      <= '0;
            mask         <= '0;
            src_q        <= '0;
            gen          <= 1'b0;
            active_id    <= '0;
            active_valid <= 1'b0;
            irq          <= 1'b0;
        end else begin
            state   <= next_state;
            irq     <= (next_state == REQUEST);
            src_q   <= src;
            pending <= pending_next;
            if (wr_en && reg_sel == REG_MASK) mask <= wr_data[NUM_SOURCES-1:0];
            if (wr_en && reg_sel == REG_CTRL) gen  <= wr_data[0];
            if (take_ack) begin
                active_id    <= winner;
                active_valid <= 1'b1;
            end else if (take_rfi) begin
                active_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        unique case (reg_sel)
            REG_PENDING: rd_data[NUM_SOURCES-1:0] = pending;
            REG_MASK:    rd_data[NUM_SOURCES-1:0] = mask;
            REG_ACTIVE: begin
                rd_data[ID_W-1:0]         = active_id;
                rd_data[ACTIVE_VALID_BIT] = active_valid;
            end
            REG_CTRL:    rd_data[0] = gen;
            default:     rd_data = '0;
        endcase
    end

    assign unused_wr_bits = ^wr_data[DATA_W-1:NUM_SOURCES];

endmodule
